// File: rtl/oscillator_scheduler_pkg.sv
// Shared oscillator/config types for the voice scheduler and its phase stepper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package oscillator_scheduler_pkg;

  localparam int PHASE_WIDTH     = 32;
  localparam int AUDIO_BIT_WIDTH = 24;

  // FRONT ramps the phase up towards all-ones; BACK ramps it down towards zero.
  typedef enum logic {
    FRONT = 1'b0,
    BACK  = 1'b1
  } oscillator_state_t;

  typedef logic [PHASE_WIDTH-1:0] long_percent_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/oscillator_scheduler_phase_stepper.sv
// Combinational next (state, phase) for one voice: triangle ramp that saturates at the ends.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether to commit the result.
// Ports: state_cur/phase_cur/inc in, state_nxt/phase_nxt out.
module oscillator_scheduler_phase_stepper
  import oscillator_scheduler_pkg::*;
#(
  parameter int PHASE_WIDTH = oscillator_scheduler_pkg::PHASE_WIDTH
) (
  input  oscillator_state_t       state_cur,
  input  logic [PHASE_WIDTH-1:0]  phase_cur,
  input  logic [PHASE_WIDTH-1:0]  inc,
  output oscillator_state_t       state_nxt,
  output logic [PHASE_WIDTH-1:0]  phase_nxt
);

  localparam logic [PHASE_WIDTH-1:0] MAX = '1;

  // Comparing against MAX-inc / inc instead of adding first avoids needing a carry bit.
  // With inc=0 neither compare fires and the add/subtract is a no-op, so the voice holds.
  always_comb begin
    state_nxt = state_cur;
    phase_nxt = phase_cur;
    if (state_cur == FRONT) begin
      if (phase_cur > (MAX - inc)) begin
        phase_nxt = MAX;
        state_nxt = BACK;
      end else begin
        phase_nxt = phase_cur + inc;
      end
    end else begin
      if (phase_cur < inc) begin
        phase_nxt = '0;
        state_nxt = FRONT;
      end else begin
        phase_nxt = phase_cur - inc;
      end
    end
  end

endmodule

// File: rtl/oscillator_scheduler.sv
// Time-multiplexes one pulse generator over VOICES voices and mixes enabled voices per sample tick.
// Latency: tick sampled at edge t -> SWEEP t+1..t+VOICES, sample_valid in t+VOICES+1 (VOICES+2 cycles to idle).
// Backpressure: none; ticks arriving while busy are dropped and latch the sticky overrun flag.
// Ports: clock/reset_l; sample_tick; cfg_we/cfg_voice/cfg_increment/cfg_enable voice config;
//        osc_state/osc_phase to generator, pulse_in back; sample_out/sample_valid mix; busy; overrun.
module oscillator_scheduler
  import oscillator_scheduler_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int PHASE_WIDTH = oscillator_scheduler_pkg::PHASE_WIDTH,
  parameter int AUDIO_WIDTH = AUDIO_BIT_WIDTH,
  localparam int VW         = $clog2(VOICES)
) (
  input  logic                    clock,
  input  logic                    reset_l,
  input  logic                    sample_tick,
  input  logic                    cfg_we,
  input  logic [VW-1:0]           cfg_voice,
  input  logic [PHASE_WIDTH-1:0]  cfg_increment,
  input  logic                    cfg_enable,
  output oscillator_state_t       osc_state,
  output logic [PHASE_WIDTH-1:0]  osc_phase,
  input  logic [AUDIO_WIDTH-1:0]  pulse_in,
  output logic [AUDIO_WIDTH-1:0]  sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int ACCW = AUDIO_WIDTH + VW;

  // Per-voice register file.
  logic [PHASE_WIDTH-1:0] phase_q [VOICES];
  oscillator_state_t      st_q    [VOICES];
  logic [PHASE_WIDTH-1:0] inc_q   [VOICES];
  logic [VOICES-1:0]      en_q;

  sched_state_t           state_q, state_d;
  logic [VW-1:0]          v_q;
  logic [ACCW-1:0]        acc_q;
  logic [ACCW-1:0]        acc_nxt;
  logic                   start;
  logic                   last_voice;

  oscillator_state_t      st_step;
  logic [PHASE_WIDTH-1:0] phase_step;

  // v_q rests at 0 outside SWEEP, so the generator sees voice 0 while idle.
  assign osc_state  = st_q[v_q];
  assign osc_phase  = phase_q[v_q];
  assign last_voice = (v_q == VW'(VOICES - 1));

  // Disabled voices contribute nothing; the generator output is still sign-extended
  // into the wide accumulator so a full sweep of extremes cannot overflow.
  assign acc_nxt = en_q[v_q] ? (acc_q + {{VW{pulse_in[AUDIO_WIDTH-1]}}, pulse_in}) : acc_q;

  oscillator_scheduler_phase_stepper #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_stepper (
    .state_cur (st_q[v_q]),
    .phase_cur (phase_q[v_q]),
    .inc       (inc_q[v_q]),
    .state_nxt (st_step),
    .phase_nxt (phase_step)
  );

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    sample_valid = 1'b0;
    start        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SWEEP;
          start   = 1'b1;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (last_voice) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
        st_q[i]    <= FRONT;
        inc_q[i]   <= '0;
      end
      en_q       <= '0;
      v_q        <= '0;
      acc_q      <= '0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      if (sample_tick && busy) begin
        overrun <= 1'b1;
      end

      if (start) begin
        v_q   <= '0;
        acc_q <= '0;
      end else if (state_q == SWEEP) begin
        // VOICES is a power of two, so the counter wraps back to 0 for IDLE/EMIT.
        v_q   <= v_q + VW'(1);
        acc_q <= acc_nxt;
        if (en_q[v_q]) begin
          phase_q[v_q] <= phase_step;
          st_q[v_q]    <= st_step;
        end
        // Load the mix at the end of the last voice so it is already new during EMIT.
        if (last_voice) begin
          sample_out <= acc_nxt[ACCW-1:VW];
        end
      end

      // Placed after the sweep update so a colliding config write wins on the
      // register file, while the sweep above already used the pre-write values.
      if (cfg_we) begin
        inc_q[cfg_voice] <= cfg_increment;
        en_q[cfg_voice]  <= cfg_enable;
        if (!cfg_enable) begin
          phase_q[cfg_voice] <= '0;
          st_q[cfg_voice]    <= FRONT;
        end
      end
    end
  end

endmodule

// File: doc/oscillator_scheduler.md
Name: oscillator_scheduler

Overview:
- Time-multiplexes one shared combinational pulse waveform generator across VOICES oscillator voices.
- Per voice it stores a phase accumulator and a FRONT/BACK oscillator state.
- On each audio sample tick it sweeps all voices, one per clock. Each step presents that voice's (state, phase) to the generator, captures the generator's pulse output and advances the voice's phase.
- It mixes the enabled voices into one output sample. It sits between the MIDI/voice-allocation config path and the audio output stage.

Parameters:
- VOICES, 8: number of voices; power of two, ≥2.
- PHASE_WIDTH, 32: width of the phase and increment (long percent).
- AUDIO_WIDTH, 24: audio sample width (AUDIO_BIT_WIDTH), two's complement.

Ports:
- clock  in  1  system clock.
- reset_l  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle strobe that starts a sweep.
- cfg_we  in  1  voice config write strobe.
- cfg_voice  in  $clog2(VOICES)  voice index for cfg write.
- cfg_increment  in  PHASE_WIDTH  per-sample phase step.
- cfg_enable  in  1  voice enable.
- osc_state  out  1  oscillator_state_t (FRONT/BACK) driven to the pulse generator.
- osc_phase  out  PHASE_WIDTH  phase driven to the pulse generator.
- pulse_in  in  AUDIO_WIDTH  generator output, combinational from osc_state/osc_phase.
- sample_out  out  AUDIO_WIDTH  mixed sample.
- sample_valid  out  1  one-cycle strobe; sample_out is new.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (async, reset_l=0):
  - all voices disabled; phase=0; state=FRONT; increment=0.
  - FSM=IDLE; voice counter=0; accumulator=0.
  - sample_out=0; sample_valid=0; busy=0; overrun=0.
  - Reset mid-sweep aborts the sweep; no sample_valid is produced.
- FSM states: IDLE, SWEEP, EMIT.
  - IDLE: sample_tick=1 → SWEEP, with v=0 and acc=0.
  - SWEEP: one voice per cycle, v=0..VOICES-1; after v=VOICES-1 → EMIT.
  - EMIT: one cycle; sample_valid=1; → IDLE.
- Latency: tick sampled at edge t gives SWEEP cycles t+1..t+VOICES and sample_valid high during cycle t+VOICES+1. Total VOICES+2 cycles tick-to-idle.
- busy=1 in SWEEP and EMIT.
- osc_state/osc_phase are combinational from the voice register file at index v.
  - In IDLE/EMIT they present voice 0. This is a don't-care downstream.
- In SWEEP, for voice v:
  - If enabled: acc += sign_extend(pulse_in). acc is AUDIO_WIDTH+$clog2(VOICES) bits, so it never overflows.
  - If disabled: contributes 0.
- Phase update of an enabled voice, with inc = cfg_increment and MAX = all-ones:
  - FRONT: if phase > MAX-inc, then phase←MAX and state←BACK; else phase←phase+inc.
  - BACK: if phase < inc, then phase←0 and state←FRONT; else phase←phase-inc.
  - inc=0: phase and state hold.
  - Disabled voices hold phase and state.
- EMIT: sample_out ← acc arithmetically shifted right by $clog2(VOICES). sample_out holds until the next EMIT.
- sample_tick while busy: ignored and sets overrun=1. overrun clears only on reset.
  - A tick in the same cycle as the EMIT→IDLE transition is also ignored.
- Config write, applied at the clock edge on cfg_we:
  - Writes increment and enable.
  - A write with cfg_enable=0 also forces phase=0 and state=FRONT.
  - A write to a voice not currently indexed takes effect for that voice's next use.
  - Collision with the voice being swept in the same cycle: the sweep uses the pre-write increment/enable for accumulation and phase update. The config write wins for increment/enable. A disabling write also wins for phase/state (forced to 0/FRONT).
- Voices are processed in ascending index order, always all VOICES, regardless of enables.

Decomposition:
- Shared package (OSCILLATOR/CONFIG): oscillator_state_t {FRONT, BACK}, long_percent_t (PHASE_WIDTH), AUDIO_BIT_WIDTH, and the scheduler FSM enum sched_state_t.
- One natural sub-module: phase_stepper, a combinational next-state/next-phase function for a single voice (state, phase, inc) → (state', phase'). It is unit-testable alone.
- The register file, FSM and mixer stay in the top.

Test Plan:
- Reset then idle: no tick for 20 cycles → sample_out=0, sample_valid=0, busy=0, overrun=0.
- VOICES=8, voice 0 enabled, inc=0x4000_0000, pulse_in stubbed to 0x000100 → sample_valid at cycle t+9 with sample_out=0x000020. Voice 0 phase sequence over ticks: 0x4000_0000, 0x8000_0000, 0xC000_0000, then 0xFFFF_FFFF with BACK, then 0xBFFF_FFFF.
- BACK wrap: voice in BACK, phase=0x0000_0010, inc=0x20 → next phase=0, state=FRONT; on the following tick phase=0x20.
- All 8 voices enabled, pulse_in=0x7FFFFF each → sample_out=0x7FFFFF. With pulse_in=0x800000 each → sample_out=0x800000 (no overflow).
- Tick asserted at t+3 during a sweep → no second sweep starts, overrun=1, sample_valid still at t+9 only.
- Config collision: write cfg_enable=0 to voice 2 in the cycle voice 2 is swept → that voice's pulse is still accumulated. Afterwards voice 2 has phase=0, state=FRONT, and is excluded from the next sweep's sum.
